// File: rtl/accel_smv_sequencer.sv
// accel_smv_sequencer: periodic ADXL362 X/Y/Z burst read, emits SMV = X^2+Y^2+Z^2.
// Define ACL_SPI_TIMEOUT_EN to add the spi_done watchdog and the TIMEOUT parameter.
module accel_smv_sequencer #(
    parameter int SAMPLE_DIV = 100_000,
    parameter int CS_GUARD   = 4
`ifdef ACL_SPI_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 4096
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        spi_busy,
    input  logic        spi_done,
    input  logic [7:0]  spi_rx_byte,
    output logic        spi_start,
    output logic [7:0]  spi_tx_byte,
    output logic        ACL_CS_n,
    output logic [31:0] SMV_out,
    output logic        smv_valid,
    output logic        overrun,
    output logic        spi_err
);

    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam int GRD_W = (CS_GUARD < 1) ? 1 : $clog2(CS_GUARD + 1);
    localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [GRD_W-1:0] GRD_LD  = GRD_W'(CS_GUARD);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_RD,
        S_SQ_X, S_SQ_Y, S_SQ_Z, S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0] r_tick_cnt;
    logic [GRD_W-1:0] r_guard;
    logic             r_wait;
    logic [2:0]       r_idx;
    logic [47:0]      r_rx;
    logic             r_start;
    logic [7:0]       r_tx;
    logic             r_cs_n;
    logic [31:0]      r_acc;
    logic [31:0]      r_smv;
    logic             r_valid;
    logic             r_ovr;

    logic               w_tick;
    logic               w_xfer;
    logic               w_issue;
    logic               w_take;
    logic               w_last;
    logic               w_go;
    logic               w_tmo;
    logic [7:0]         w_tx_byte;
    logic signed [15:0] w_s;
    logic signed [31:0] w_prod;
    logic [31:0]        w_sq;

    assign w_tick  = enable && (r_tick_cnt == TICK_AT);
    assign w_xfer  = (r_state == S_CMD) || (r_state == S_ADDR)
                  || (r_state == S_RD);
    assign w_issue = w_xfer && !r_wait && !spi_busy;
    assign w_take  = w_xfer && r_wait && spi_done;
    assign w_last  = (r_state == S_RD) && w_take && (r_idx == 3'd5);
    assign w_go    = (r_state == S_IDLE) && w_tick
                  && (r_guard == '0) && !spi_busy;

    assign w_tx_byte = (r_state == S_CMD)  ? 8'h0B :
                       (r_state == S_ADDR) ? 8'h0E : 8'h00;

    // Bytes arrive XL,XH,YL,YH,ZL,ZH and are shifted in from the top
    always_comb begin
        w_s = r_rx[15:0];
        if (r_state == S_SQ_Y) begin
            w_s = r_rx[31:16];
        end else if (r_state == S_SQ_Z) begin
            w_s = r_rx[47:32];
        end
    end

    assign w_prod = 32'(w_s) * 32'(w_s);
    assign w_sq   = w_prod;

`ifdef ACL_SPI_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] r_wd;
    logic            r_err;

    assign w_tmo = w_xfer && r_wait && !spi_done && (r_wd == WD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_issue) begin
                r_wd <= '0;
            end else if (w_xfer && r_wait) begin
                r_wd <= r_wd + 1'b1;
            end
            if (w_tmo) begin
                r_err <= 1'b1;
            end
        end
    end

    assign spi_err = r_err;
`else
    assign w_tmo   = 1'b0;
    assign spi_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_go) w_state_nxt = S_CMD;
            S_CMD: begin
                if (w_tmo) w_state_nxt = S_IDLE;
                else if (w_take) w_state_nxt = S_ADDR;
            end
            S_ADDR: begin
                if (w_tmo) w_state_nxt = S_IDLE;
                else if (w_take) w_state_nxt = S_RD;
            end
            S_RD: begin
                if (w_tmo) w_state_nxt = S_IDLE;
                else if (w_last) w_state_nxt = S_SQ_X;
            end
            S_SQ_X: w_state_nxt = S_SQ_Y;
            S_SQ_Y: w_state_nxt = S_SQ_Z;
            S_SQ_Z: w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_guard    <= GRD_LD;
            r_wait     <= 1'b0;
            r_idx      <= '0;
            r_rx       <= '0;
            r_start    <= 1'b0;
            r_tx       <= '0;
            r_cs_n     <= 1'b1;
            r_acc      <= '0;
            r_smv      <= '0;
            r_valid    <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            if (!enable || w_tick) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end

            r_start <= w_issue;
            r_valid <= (r_state == S_DONE);

            if (w_issue) begin
                r_tx   <= w_tx_byte;
                r_wait <= 1'b1;
            end else if (w_take || w_tmo) begin
                r_wait <= 1'b0;
            end

            if (r_state == S_CMD) begin
                r_idx <= '0;
            end else if (w_take && (r_state == S_RD)) begin
                r_idx <= r_idx + 1'b1;
                r_rx  <= {spi_rx_byte, r_rx[47:8]};
            end

            if (w_go) begin
                r_cs_n <= 1'b0;
            end else if (w_last || w_tmo) begin
                r_cs_n <= 1'b1;
            end

            // Guard only drains while CS is high, so it measures the CS-high gap
            if (w_last || w_tmo) begin
                r_guard <= GRD_LD;
            end else if (r_cs_n && (r_guard != '0)) begin
                r_guard <= r_guard - 1'b1;
            end

            if (w_tick && (r_state != S_IDLE)) begin
                r_ovr <= 1'b1;
            end

            case (r_state)
                S_CMD:          r_acc <= '0;
                S_SQ_X, S_SQ_Y: r_acc <= r_acc + w_sq;
                S_SQ_Z:         r_smv <= r_acc + w_sq;
                default: ;
            endcase
        end
    end

    assign spi_start   = r_start;
    assign spi_tx_byte = r_tx;
    assign ACL_CS_n    = r_cs_n | reset;
    assign SMV_out     = r_smv;
    assign smv_valid   = r_valid;
    assign overrun     = r_ovr;

endmodule

// File: tb/tb_accel_smv_sequencer.sv
// Bench for accel_smv_sequencer: SPI byte-engine model plus burst/SMV scoreboard.
// Timeout scenario runs only when ACL_SPI_TIMEOUT_EN is defined.
module tb_accel_smv_sequencer;

    localparam int DIV = 200;
    localparam int GRD = 4;
    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        spi_busy = 1'b0;
    logic        spi_done = 1'b0;
    logic [7:0]  spi_rx_byte = 8'h00;
    logic        spi_start;
    logic [7:0]  spi_tx_byte;
    logic        ACL_CS_n;
    logic [31:0] SMV_out;
    logic        smv_valid;
    logic        overrun;
    logic        spi_err;

    accel_smv_sequencer #(
        .SAMPLE_DIV(DIV),
        .CS_GUARD(GRD)
`ifdef ACL_SPI_TIMEOUT_EN
        ,
        .TIMEOUT(TMO)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .spi_busy(spi_busy),
        .spi_done(spi_done),
        .spi_rx_byte(spi_rx_byte),
        .spi_start(spi_start),
        .spi_tx_byte(spi_tx_byte),
        .ACL_CS_n(ACL_CS_n),
        .SMV_out(SMV_out),
        .smv_valid(smv_valid),
        .overrun(overrun),
        .spi_err(spi_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] smv_of(input logic [15:0] x,
                                           input logic [15:0] y,
                                           input logic [15:0] z);
        longint sx, sy, sz;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sz = longint'($signed(z));
        return 32'(sx * sx + sy * sy + sz * sz);
    endfunction

    logic [15:0] vx = 16'h0, vy = 16'h0, vz = 16'h0;

    function automatic logic [7:0] rx_of(input int n);
        case (n)
            2: return vx[7:0];
            3: return vx[15:8];
            4: return vy[7:0];
            5: return vy[15:8];
            6: return vz[7:0];
            7: return vz[15:8];
            default: return 8'hA5;
        endcase
    endfunction

    function automatic logic [7:0] exp_tx(input int n);
        if (n == 0) return 8'h0B;
        if (n == 1) return 8'h0E;
        return 8'h00;
    endfunction

    typedef struct {
        int          due;
        logic [31:0] smv;
    } pend_t;

    pend_t pend[$];
    int    cyc = 0;
    int    lat = 4;
    bit    hang = 1'b0;
    int    hang_t = -1;
    int    nstart = 0;
    int    ndone = 0;
    int    frames = 0;
    int    gap = 1000;
    logic  prev_cs = 1'b1;

    // SPI engine model and per-cycle scoreboard
    initial begin
        int   cnt;
        bit   exp_v;
        bit   exp_err;
        logic [7:0] cur_tx;
        cnt = 0;
        cur_tx = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                spi_busy = 1'b0;
                spi_done = 1'b0;
                nstart = 0;
                ndone = 0;
                pend.delete();
                prev_cs = 1'b1;
                gap = 1000;
                cnt = 0;
            end else begin
                exp_v = (pend.size() > 0) && (pend[0].due == cyc);
                chk("smv_valid", smv_valid, exp_v);
                if (exp_v) chk("smv_value", SMV_out, pend[0].smv);
                if (pend.size() > 0 && pend[0].due <= cyc)
                    void'(pend.pop_front());
                exp_err = (hang_t >= 0) && (cyc >= hang_t + TMO);
                chk("spi_err", spi_err, exp_err);
                if (hang_t >= 0 && cyc == hang_t + TMO)
                    chk("cs_at_timeout", ACL_CS_n, 1);

                if (!ACL_CS_n && prev_cs) begin
                    frames++;
                    chk("cs_guard_gap", gap >= GRD, 1);
                    nstart = 0;
                    ndone = 0;
                end
                if (ACL_CS_n && !prev_cs) begin
                    if (!hang) chk("frame_bytes", nstart, 8);
                    gap = 0;
                end
                if (ACL_CS_n) gap++;
                prev_cs = ACL_CS_n;

                spi_done = 1'b0;
                if (spi_start) begin
                    chk("start_busy_cs", {spi_busy, ACL_CS_n}, 0);
                    chk("tx_byte", spi_tx_byte, exp_tx(nstart));
                    cur_tx = spi_tx_byte;
                    nstart++;
                    spi_busy = 1'b1;
                    cnt = lat;
                    if (hang && hang_t < 0) hang_t = cyc;
                end else if (spi_busy) begin
                    cnt--;
                    if (cnt == 0) begin
                        spi_busy = 1'b0;
                        if (!hang) begin
                            chk("tx_stable", spi_tx_byte, cur_tx);
                            spi_rx_byte = rx_of(ndone);
                            spi_done = 1'b1;
                            ndone++;
                            if (ndone == 8)
                                pend.push_back('{cyc + 5, smv_of(vx, vy, vz)});
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input string nm, input int budget);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!smv_valid && k < budget);
        chk(nm, smv_valid, 1);
    endtask

    initial begin
        #900_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        int k;
        int fr;

        repeat (3) step();
        chk("rst_cs", ACL_CS_n, 1);
        chk("rst_start", spi_start, 0);
        chk("rst_tx", spi_tx_byte, 0);
        chk("rst_smv", SMV_out, 0);
        chk("rst_valid", smv_valid, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_err", spi_err, 0);
        reset = 1'b0;

        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            step();
            if (spi_start || !ACL_CS_n || smv_valid) bad++;
        end
        chk("disabled_quiet", bad, 0);
        chk("disabled_frames", frames, 0);
        chk("disabled_smv", SMV_out, 0);

        vx = 16'h0100; vy = 16'h0000; vz = 16'hFF00;
        enable = 1'b1;
        wait_valid("t2_valid", 1000);
        chk("t2_smv", SMV_out, 32'h0002_0000);
        chk("t2_frames", frames, 1);

        vx = 16'h07FF; vy = 16'hF800; vz = 16'h0000;
        wait_valid("t3_valid", 1000);
        chk("t3_smv", SMV_out, 32'h007F_F001);

        vx = 16'hF800; vy = 16'hF800; vz = 16'hF800;
        wait_valid("max_valid", 1000);
        chk("max_smv", SMV_out, 32'h00C0_0000);
        chk("no_overrun_yet", overrun, 0);

        vx = 16'h0003; vy = 16'hFFFC; vz = 16'h000C;
        k = 0;
        do begin
            step();
            k++;
        end while (ACL_CS_n && k < 500);
        chk("drop_cs_low", ACL_CS_n, 0);
        enable = 1'b0;
        wait_valid("drop_valid", 1000);
        chk("drop_smv", SMV_out, 32'h0000_00A9);
        fr = frames;
        repeat (600) step();
        chk("drop_no_new_frame", frames, fr);
        chk("drop_cs_high", ACL_CS_n, 1);

        lat = 30;
        vx = 16'h0010; vy = 16'h0020; vz = 16'h0030;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) wait_valid("ovr_valid", 1000);
        chk("ovr_smv", SMV_out, 32'h0000_0E00);
        chk("ovr_flag", overrun, 1);
        enable = 1'b0;
        repeat (400) step();
        lat = 4;

        vx = 16'h0001; vy = 16'h0002; vz = 16'h0003;
        enable = 1'b1;
        k = 0;
        do begin
            step();
            k++;
        end while (ndone < 3 && k < 1000);
        chk("rst_mid_reach", ndone >= 3, 1);
        reset = 1'b1;
        #1;
        chk("rst_mid_cs_now", ACL_CS_n, 1);
        step();
        chk("rst_mid_cs", ACL_CS_n, 1);
        chk("rst_mid_smv", SMV_out, 0);
        chk("rst_mid_ovr", overrun, 0);
        chk("rst_mid_start", spi_start, 0);
        reset = 1'b0;
        wait_valid("rst_clean_valid", 1000);
        chk("rst_clean_smv", SMV_out, 32'h0000_000E);

`ifdef ACL_SPI_TIMEOUT_EN
        hang = 1'b1;
        k = 0;
        do begin
            step();
            k++;
        end while (!spi_err && k < 600);
        chk("tmo_err", spi_err, 1);
        chk("tmo_cs", ACL_CS_n, 1);
        chk("tmo_smv_kept", SMV_out, 32'h0000_000E);
        repeat (3) step();
        hang = 1'b0;
        vx = 16'h0005; vy = 16'h0000; vz = 16'h0000;
        wait_valid("tmo_recover_valid", 1000);
        chk("tmo_recover_smv", SMV_out, 32'h0000_0019);
`else
        chk("err_tied_low", spi_err, 0);
`endif

        enable = 1'b0;
        repeat (10) step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
